// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// State encodings are fixed so waveforms and debug tools can decode them.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MDU_WAIT  = 2'd1,
        MDU_DRAIN = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
// It holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Registered stall/flush controller for the 5-stage pipeline: arbitrates
// taken branches, MDU occupancy and load-use hazards, and keeps statistics.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned MDU_MAX_CYC = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             branch_taken_ex,
    input  logic             ex_mdu_op,
    input  logic             mdu_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             mdu_start,
    output logic             mdu_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned      TMO_W    = $clog2(MDU_MAX_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MDU_MAX_CYC - 1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_clr, tmo_inc, err_set, flush_inc;
    logic             load_hz;

    assign load_hz = idex_mem_read && (idex_rt != REG_ZERO) &&
                     ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            tmo_q   <= '0;
            mdu_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (tmo_clr) begin
                tmo_q <= '0;
            end else if (tmo_inc) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (err_set) begin
                mdu_err <= 1'b1;
            end
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mdu_start   = 1'b0;
        state_d     = state_q;
        tmo_clr     = 1'b0;
        tmo_inc     = 1'b0;
        err_set     = 1'b0;
        flush_inc   = 1'b0;
        case (state_q)
            RUN: begin
                if (branch_taken_ex) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (ex_mdu_op) begin
                    mdu_start   = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_flush = 1'b1;
                    tmo_clr     = 1'b1;
                    state_d     = MDU_WAIT;
                end else if (load_hz) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MDU_WAIT: begin
                // Hazard and branch inputs are ignored: EX is frozen on the MDU op.
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_flush = 1'b1;
                if (mdu_done) begin
                    state_d = MDU_DRAIN;
                end else if (tmo_q == TMO_LAST) begin
                    err_set = 1'b1;
                    state_d = MDU_DRAIN;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            MDU_DRAIN: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (!pc_write),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (flush_inc),
        .cnt   (flush_cnt)
    );

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Sequential stall/flush controller for the 5-stage MIPS pipeline. It replaces purely combinational hazard gating with a registered state machine that arbitrates three stall sources: load-use hazards, taken branches resolved in EX, and a multi-cycle multiply/divide unit (MDU) occupying EX. It drives every pipeline-register write-enable and flush, and keeps saturating stall and flush statistics counters.

## Interface
Parameters:
- MDU_MAX_CYC, 64: MDU timeout in cycles, ≥2.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- idex_mem_read  in  1  the instruction in ID/EX is a load.
- idex_rt  in  5  destination register of the load in ID/EX.
- ifid_rs  in  5  rs field of the instruction in ID.
- ifid_rt  in  5  rt field of the instruction in ID.
- ifid_uses_rt  in  1  the ID instruction reads rt.
- branch_taken_ex  in  1  taken branch or jump resolved in EX (PCSrc).
- ex_mdu_op  in  1  the EX instruction is an MDU operation.
- mdu_done  in  1  one-cycle pulse: MDU result ready.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID write enable.
- idex_write  out  1  ID/EX write enable.
- ifid_flush  out  1  zero IF/ID on the next edge.
- idex_flush  out  1  load a bubble into ID/EX on the next edge.
- exmem_flush  out  1  load a bubble into EX/MEM on the next edge.
- mdu_start  out  1  one-cycle pulse that launches the MDU.
- mdu_err  out  1  sticky flag: MDU timeout occurred.
- stall_cnt  out  CNT_W  count of cycles with pc_write=0, saturating.
- flush_cnt  out  CNT_W  count of taken-branch flushes, saturating.

## Operation
States: RUN, MDU_WAIT, MDU_DRAIN.

- load_hz = idex_mem_read && idex_rt≠0 && (idex_rt==ifid_rs || (ifid_uses_rt && idex_rt==ifid_rt)).

RUN. Default outputs: all write enables = 1, all flushes = 0.
- Priority 1, branch_taken_ex: ifid_flush=1, idex_flush=1, pc_write=1. Overrides load_hz. Increments flush_cnt.
- Priority 2, ex_mdu_op with no branch: mdu_start=1, pc_write=0, ifid_write=0, idex_write=0, exmem_flush=1. Next state is MDU_WAIT, and the timeout counter clears.
- Priority 3, load_hz: pc_write=0, ifid_write=0, idex_flush=1. Lasts exactly one cycle and stays in RUN, because the bubble removes the hazard.

MDU_WAIT:
- Outputs: pc_write=0, ifid_write=0, idex_write=0, exmem_flush=1. load_hz and branch_taken_ex are ignored.
- On mdu_done, go to MDU_DRAIN.
- Otherwise, when the timeout counter reaches MDU_MAX_CYC-1, set mdu_err and go to MDU_DRAIN.

MDU_DRAIN:
- One cycle with all write enables = 1 and exmem_flush = 0. The MDU result advances to MEM.
- Go to RUN.
- ex_mdu_op is ignored in this cycle. The new EX instruction is evaluated from RUN on the next cycle.

Counters:
- stall_cnt increments on every cycle with pc_write=0 and saturates at all-ones.
- flush_cnt saturates the same way.
- mdu_err is cleared only by reset.

## Timing
- Outputs are combinational from the state and inputs. State, the timeout counter, mdu_err and the statistics counters are registered.
- Reset (rst_i=0) forces these values immediately:
  - state=RUN, counters=0, mdu_err=0.
  - Outputs in RUN with inputs low: pc_write=1, ifid_write=1, idex_write=1, all flushes=0, mdu_start=0.
- Reset asserted mid-MDU_WAIT returns to RUN and does not pulse mdu_start.
- Load-use penalty: 1 cycle.
- Branch penalty: 2 flushed slots, in the same cycle as branch_taken_ex.
- MDU stall cycles = 1 (issue) + N (N cycles from mdu_start to mdu_done) + 0.
- mdu_done arriving in the same cycle as mdu_start is ignored, since the state is still RUN.

## Structure
- Shared package holds:
  - the state enum: RUN=2'd0, MDU_WAIT=2'd1, MDU_DRAIN=2'd2;
  - the REG_ZERO constant 5'd0.
- Sub-module sat_counter (parameter W; inputs inc, clk_i, rst_i) is instantiated twice.
- Timeout counter width: $clog2(MDU_MAX_CYC).

## Test plan
- Load-use stall: reset, then idex_mem_read=1, idex_rt=8, ifid_rs=8 → one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1.
- Zero-register filter: same stimulus with idex_rt=0 → no stall, stall_cnt=0.
- Branch over load-use: branch_taken_ex=1 together with load_hz → ifid_flush=1, idex_flush=1, pc_write=1; flush_cnt=1; stall_cnt unchanged.
- MDU 5-cycle op: ex_mdu_op=1, mdu_done pulsed 5 cycles after mdu_start → mdu_start asserted for exactly 1 cycle; pc_write=0 for 6 cycles; MDU_DRAIN for one cycle; stall_cnt=6.
- MDU timeout: MDU_MAX_CYC=8, mdu_done never asserted → mdu_err=1 after 8 cycles in MDU_WAIT; return to RUN; mdu_err stays 1 until rst_i=0.
- Reset mid-MDU_WAIT and saturation:
  - rst_i=0 in cycle 3 of MDU_WAIT → outputs return to their reset values immediately.
  - With CNT_W=4, 20 load-use stalls → stall_cnt=15.
